// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: BCD stopwatch with run/pause/lap/overflow control FSM
module stopwatch_ctrl #(
  parameter int TICK_DIV = 32,
  parameter int DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [31:0] Data,
  output logic [2:0]  state,
  output logic        running,
  output logic        ovf
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] LAP = 3'd3;
  localparam logic [2:0] OVF = 3'd4;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre, pre_n;
  logic [31:0] count, count_n, inc, lap_reg;
  logic [2:0] state_n;
  logic act, tick, all9, cl, ss, lp;
  assign act = state == RUN || state == LAP;
  assign tick = act && pre == PW'(TICK_DIV - 1);
  assign cl = clear;
  assign ss = !clear && start_stop;
  assign lp = !clear && !start_stop && lap;
  assign running = act;
  assign ovf = state == OVF;
  assign Data = state == LAP ? lap_reg : count;
  // BCD increment across the active digits; all9 means the increment would overflow
  always_comb begin
    inc = '0;
    all9 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < DIGITS) begin
        inc[4*i+:4] = all9 ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
        all9 = all9 & (count[4*i+:4] == 4'd9);
      end
    end
  end
  // next-state, count and prescaler; a saturating tick forces OVF over any command
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = ss ? RUN : IDLE;
      RUN: state_n = ss ? PAUSE : lp ? LAP : RUN;
      LAP: state_n = ss ? PAUSE : lp ? RUN : LAP;
      PAUSE: state_n = cl ? IDLE : ss ? RUN : PAUSE;
      OVF: state_n = cl ? IDLE : OVF;
      default: state_n = IDLE;
    endcase
    if (tick && all9) state_n = OVF;
    count_n = state_n == IDLE ? '0 : (tick && !all9) ? inc : count;
    pre_n = state_n == IDLE ? '0 : tick ? '0 : act ? pre + 1'b1 : pre;
  end
  // state registers with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      lap_reg <= '0;
      pre <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      pre <= pre_n;
      if (state == RUN && lp) lap_reg <= count;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of stopwatch_ctrl in default and 2-digit configurations
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [31:0] Data, d2;
  logic [2:0] state, s2;
  logic running, ovf, r2, o2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stopwatch_ctrl #(.TICK_DIV(4), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .Data(Data), .state(state), .running(running), .ovf(ovf)
  );
  stopwatch_ctrl #(.TICK_DIV(1), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .Data(d2), .state(s2), .running(r2), .ovf(o2)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic c, input logic s, input logic l);
    clear = c;
    start_stop = s;
    lap = l;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    checks++; if (Data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", Data, 32'h0); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, 0); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp %b", running, 1'b0); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp %b", ovf, 1'b0); end
  endtask
  task automatic test_run;
    pulse(0, 1, 0);
    step(40);
    checks++; if (Data !== 32'h10) begin errors++; $display("FAIL run_data got %h exp %h", Data, 32'h10); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_state got %0d exp %0d", state, 1); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b exp %b", running, 1'b1); end
  endtask
  task automatic test_lap;
    step(60);
    checks++; if (Data !== 32'h25) begin errors++; $display("FAIL lap_pre got %h exp %h", Data, 32'h25); end
    pulse(0, 0, 1);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL lap_state got %0d exp %0d", state, 3); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got %b exp %b", running, 1'b1); end
    step(20);
    checks++; if (Data !== 32'h25) begin errors++; $display("FAIL lap_frozen got %h exp %h", Data, 32'h25); end
    pulse(0, 0, 1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL lap_back_state got %0d exp %0d", state, 1); end
    checks++; if (Data !== 32'h30) begin errors++; $display("FAIL lap_live got %h exp %h", Data, 32'h30); end
  endtask
  task automatic test_clear_pause;
    pulse(1, 0, 0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL clr_run_state got %0d exp %0d", state, 1); end
    checks++; if (Data !== 32'h30) begin errors++; $display("FAIL clr_run_data got %h exp %h", Data, 32'h30); end
    pulse(0, 1, 0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_state got %0d exp %0d", state, 2); end
    checks++; if (Data !== 32'h31) begin errors++; $display("FAIL pause_tick got %h exp %h", Data, 32'h31); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b exp %b", running, 1'b0); end
    step(50);
    checks++; if (Data !== 32'h31) begin errors++; $display("FAIL pause_hold got %h exp %h", Data, 32'h31); end
    pulse(1, 0, 0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL pause_clr_state got %0d exp %0d", state, 0); end
    checks++; if (Data !== 32'h0) begin errors++; $display("FAIL pause_clr_data got %h exp %h", Data, 32'h0); end
  endtask
  task automatic test_same_cycle;
    pulse(0, 1, 0);
    step(9);
    pulse(0, 1, 0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL sc_pause_state got %0d exp %0d", state, 2); end
    checks++; if (Data !== 32'h2) begin errors++; $display("FAIL sc_pause_data got %h exp %h", Data, 32'h2); end
    step(7);
    checks++; if (Data !== 32'h2) begin errors++; $display("FAIL sc_partial_hold got %h exp %h", Data, 32'h2); end
    pulse(1, 1, 0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL sc_clr_ss_state got %0d exp %0d", state, 0); end
    checks++; if (Data !== 32'h0) begin errors++; $display("FAIL sc_clr_ss_data got %h exp %h", Data, 32'h0); end
    pulse(0, 1, 0);
    step(8);
    pulse(0, 1, 1);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL sc_ss_lap_state got %0d exp %0d", state, 2); end
    checks++; if (Data !== 32'h2) begin errors++; $display("FAIL sc_ss_lap_data got %h exp %h", Data, 32'h2); end
  endtask
  task automatic test_ovf;
    do_reset();
    pulse(0, 1, 0);
    step(10);
    checks++; if (d2 !== 32'h10) begin errors++; $display("FAIL ovf_carry got %h exp %h", d2, 32'h10); end
    step(90);
    checks++; if (d2 !== 32'h99) begin errors++; $display("FAIL ovf_data got %h exp %h", d2, 32'h99); end
    checks++; if (s2 !== 3'd4) begin errors++; $display("FAIL ovf_state got %0d exp %0d", s2, 4); end
    checks++; if (o2 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp %b", o2, 1'b1); end
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL ovf_running got %b exp %b", r2, 1'b0); end
    pulse(0, 1, 0);
    checks++; if (s2 !== 3'd4) begin errors++; $display("FAIL ovf_ss_ignored got %0d exp %0d", s2, 4); end
    checks++; if (d2 !== 32'h99) begin errors++; $display("FAIL ovf_ss_data got %h exp %h", d2, 32'h99); end
    pulse(1, 0, 0);
    checks++; if (s2 !== 3'd0) begin errors++; $display("FAIL ovf_clr_state got %0d exp %0d", s2, 0); end
    checks++; if (d2 !== 32'h0) begin errors++; $display("FAIL ovf_clr_data got %h exp %h", d2, 32'h0); end
  endtask
  task automatic test_rst_mid_lap;
    do_reset();
    pulse(0, 1, 0);
    step(5);
    pulse(0, 0, 1);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rl_lap_state got %0d exp %0d", state, 3); end
    checks++; if (Data !== 32'h1) begin errors++; $display("FAIL rl_lap_data got %h exp %h", Data, 32'h1); end
    rst = 1'b1;
    start_stop = 1'b1;
    step(1);
    rst = 1'b0;
    start_stop = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rl_state got %0d exp %0d", state, 0); end
    checks++; if (Data !== 32'h0) begin errors++; $display("FAIL rl_data got %h exp %h", Data, 32'h0); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rl_running got %b exp %b", running, 1'b0); end
    pulse(0, 1, 0);
    step(3);
    checks++; if (Data !== 32'h0) begin errors++; $display("FAIL rl_phase_pre got %h exp %h", Data, 32'h0); end
    step(1);
    checks++; if (Data !== 32'h1) begin errors++; $display("FAIL rl_phase_tick got %h exp %h", Data, 32'h1); end
  endtask
  initial begin
    step(1);
    test_reset();
    test_run();
    test_lap();
    test_clear_pause();
    test_same_cycle();
    test_ovf();
    test_rst_mid_lap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 32: clk cycles per count tick, legal range 1..2^21.
REQ-002 SHALL have parameter DIGITS, default 8: number of active BCD digits, legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start_stop, input, 1 bit: one-cycle command pulse that toggles run/pause.
REQ-006 SHALL have port lap, input, 1 bit: one-cycle command pulse that freezes or unfreezes the display.
REQ-007 SHALL have port clear, input, 1 bit: one-cycle command pulse that zeroes the count.
REQ-008 SHALL have port Data, output, 32 bits: display value, nibble i = BCD digit i, nibble 0 = least significant; feeds the scan-display block.
REQ-009 SHALL have port state, output, 3 bits: current FSM state code.
REQ-010 SHALL have port running, output, 1 bit: 1 in RUN or LAP.
REQ-011 SHALL have port ovf, output, 1 bit: 1 in OVF.

Function
REQ-012 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, LAP=3, OVF=4; codes 5..7 SHALL return to IDLE on the next cycle.
REQ-013 SHALL apply command priority clear > start_stop > lap when several pulses are high in the same cycle; lower-priority pulses in that cycle are dropped.
REQ-014 IDLE: start_stop -> RUN; clear and lap ignored; count = 0.
REQ-015 RUN: start_stop -> PAUSE; lap -> LAP and capture count into lap_reg on the same edge; clear ignored.
REQ-016 LAP: lap -> RUN; start_stop -> PAUSE (display returns live); clear ignored; count keeps advancing.
REQ-017 PAUSE: start_stop -> RUN; clear -> IDLE with count and prescaler zeroed on the same edge; lap ignored.
REQ-018 OVF: clear -> IDLE with count and prescaler zeroed; all other commands ignored.
REQ-019 Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP; held in PAUSE so a partial tick is kept; zeroed in IDLE; tick is high for the one cycle in which the prescaler equals TICK_DIV-1, and the prescaler wraps to 0 on that cycle.
REQ-020 On a tick cycle the count SHALL increment by 1 in BCD, with the new value visible the next cycle; a digit at 9 wraps to 0 and carries into the next digit in the same cycle.
REQ-021 Digits at index DIGITS..7 SHALL always read 0; a digit SHALL never hold a value above 9.
REQ-022 A tick while every active digit is 9 SHALL leave the count at all-9s and move the FSM to OVF on that edge.
REQ-023 A command that changes the state SHALL take effect on the same edge as a coincident tick; the tick increment still applies if the pre-edge state was RUN/LAP, unless clear wins.
REQ-024 Data = lap_reg in LAP, otherwise the live count; selected combinationally from registers, zero added latency.
REQ-025 running and ovf SHALL decode combinationally from the state register.

Reset
REQ-026 With rst high at a clk edge: state=IDLE, count=0, lap_reg=0, prescaler=0, so Data=0x00000000, running=0, ovf=0 from the next cycle.
REQ-027 rst SHALL override every command and tick in the same cycle, including when asserted mid-RUN or mid-LAP.

Verification (TICK_DIV=4 unless stated)
REQ-028 Reset, then start_stop pulse and 40 cycles -> Data=0x00000010, state=RUN, running=1.
REQ-029 In RUN, pulse lap at count 0x25, wait 20 cycles -> Data stays 0x00000025 while the internal count reaches 0x30; second lap -> Data live, equal to 0x30.
REQ-030 In RUN, pulse clear -> ignored; start_stop -> PAUSE, Data frozen for 50 cycles; clear -> IDLE, Data=0.
REQ-031 Same-cycle clear+start_stop in PAUSE -> IDLE, Data=0; same-cycle start_stop+lap in RUN -> PAUSE, Data=live count.
REQ-032 DIGITS=2, TICK_DIV=1: start and run 100 cycles -> Data=0x00000099, state=OVF, ovf=1; start_stop ignored; clear -> IDLE.
REQ-033 rst pulsed mid-LAP -> the next cycle shows state=IDLE, Data=0; prescaler phase restarts from 0 on the next start.
